i2c_eeprom_slave_ctrl: RTL and testbench

I2C slave protocol front end for the I2C EEPROM model on the Avalon slave side. It sits directly upstream of the 32-page × 8-byte paged EEPROM array. It decodes START/STOP, device address, word address, and data bytes from oversampled SCL/SDA. Writes are collected in an 8-byte page buffer and committed to the array as one 64-bit page write on STOP; reads are served byte-wise from the array's page output.

---
 rtl/i2c_eeprom_pkg.sv | 13 +
 rtl/i2c_line_sync.sv | 39 +++
 rtl/i2c_eeprom_slave_ctrl.sv | 120 ++++++++++++
 tb/tb_i2c_eeprom_slave_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/i2c_eeprom_pkg.sv
// i2c_eeprom_pkg: shared sizes and FSM states for the I2C EEPROM slave front end
package i2c_eeprom_pkg;
  localparam int PAGE_BYTES = 8;
  localparam int PAGE_W = 64;
  localparam int ROW_W = 5;
  localparam int COL_W = 3;
  localparam int PTR_W = ROW_W + COL_W;
  localparam logic [6:0] DEV_ADDR_DEF = 7'b1010000;
  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_WORD_ADDR, S_WORD_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes raw SCL/SDA and emits registered edge and START/STOP strobes
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);
  logic [1:0] scl_s, sda_s;
  logic scl_p, sda_p;
  // idle bus is high, so reset to 1 to avoid a spurious edge right after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start <= 1'b0;
      stop <= 1'b0;
      sda <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl_pin};
      sda_s <= {sda_s[0], sda_pin};
      scl_p <= scl_s[1];
      sda_p <= sda_s[1];
      scl_rise <= scl_s[1] & ~scl_p;
      scl_fall <= ~scl_s[1] & scl_p;
      start <= scl_s[1] & scl_p & sda_p & ~sda_s[1];
      stop <= scl_s[1] & scl_p & ~sda_p & sda_s[1];
      sda <= sda_s[1];
    end
  end
endmodule

// File: rtl/i2c_eeprom_slave_ctrl.sv
// i2c_eeprom_slave_ctrl: I2C slave protocol front end for a paged EEPROM array
module i2c_eeprom_slave_ctrl import i2c_eeprom_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int PAGE_NUM = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic [ROW_W-1:0] mem_row,
  input  logic [PAGE_W-1:0] mem_page_q,
  output logic [PAGE_W-1:0] mem_wdata,
  output logic mem_write,
  output logic busy
);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PAGE_NUM - 1);
  logic scl_rise, scl_fall, start, stop, sda;
  state_t state;
  logic [2:0] cnt;
  logic [7:0] sh, nb, rd_byte;
  logic [PTR_W-1:0] ptr, ptr_inc;
  logic [COL_W-1:0] col;
  logic [PAGE_BYTES-1:0][7:0] pbuf;
  logic dirty, preload, got, rd_load;
  i2c_line_sync u_sync (
    .clk(clk), .rst(rst), .scl_pin(scl_i), .sda_pin(sda_i),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop), .sda(sda)
  );
  assign col = ptr[COL_W-1:0];
  assign mem_row = ptr[COL_W +: ROW_W];
  assign nb = {sh[6:0], sda};
  assign rd_byte = mem_page_q[{col, 3'd0} +: 8];
  assign ptr_inc = (ptr == {LAST_ROW, {COL_W{1'b1}}}) ? '0 : ptr + 1'b1;
  // sh[0] still holds the R/W bit while in DEV_ACK; got marks a master ACK seen in RD_ACK
  assign rd_load = (state == S_DEV_ACK && sda_oe && sh[0]) || (state == S_RD_ACK && got);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      sh <= '0;
      ptr <= '0;
      pbuf <= '0;
      dirty <= 1'b0;
      preload <= 1'b0;
      got <= 1'b0;
      sda_oe <= 1'b0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      busy <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      preload <= 1'b0;
      if (preload) pbuf <= mem_page_q;
      if (stop) begin
        state <= S_IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
        dirty <= 1'b0;
        mem_write <= dirty;
        if (dirty) mem_wdata <= pbuf;
      end else if (start) begin
        state <= S_DEV_ADDR;
        cnt <= '0;
        sda_oe <= 1'b0;
        dirty <= 1'b0;
        got <= 1'b0;
      end else if (scl_rise) begin
        if (state inside {S_DEV_ADDR, S_WORD_ADDR, S_WR_DATA, S_RD_DATA}) begin
          sh <= nb;
          cnt <= cnt + 1'b1;
        end
        if (cnt == 3'd7)
          case (state)
            S_DEV_ADDR: begin
              state <= (nb[7:1] == DEV_ADDR) ? S_DEV_ACK : S_WAIT_STOP;
              busy <= nb[7:1] == DEV_ADDR;
            end
            S_WORD_ADDR: begin
              state <= S_WORD_ACK;
              ptr <= nb;
              preload <= 1'b1;
            end
            S_WR_DATA: begin
              state <= S_WR_ACK;
              pbuf[col] <= nb;
              ptr[COL_W-1:0] <= col + 1'b1;
              dirty <= 1'b1;
            end
            S_RD_DATA: begin
              state <= S_RD_ACK;
              ptr <= ptr_inc;
              got <= 1'b0;
            end
            default: ;
          endcase
        if (state == S_RD_ACK) begin
          state <= sda ? S_WAIT_STOP : S_RD_ACK;
          got <= ~sda;
        end
      end else if (scl_fall) begin
        if (rd_load) begin
          state <= S_RD_DATA;
          sh <= rd_byte;
          sda_oe <= ~rd_byte[7];
          got <= 1'b0;
        end else
          case (state)
            S_DEV_ACK, S_WORD_ACK, S_WR_ACK: begin
              sda_oe <= ~sda_oe;
              if (sda_oe) state <= (state == S_DEV_ACK) ? S_WORD_ADDR : S_WR_DATA;
            end
            S_RD_DATA: sda_oe <= ~sh[7];
            S_RD_ACK: sda_oe <= 1'b0;
            default: ;
          endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_slave_ctrl.sv
// tb_i2c_eeprom_slave_ctrl: directed I2C master against the slave front end and a page array model
`timescale 1ns/1ps
module tb_i2c_eeprom_slave_ctrl;
  typedef struct {
    logic [7:0] waddr;
    int n;
    logic [9:0][7:0] d;
    logic [4:0] row;
    logic [63:0] page;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1, mem_init = 1'b1;
  logic scl_i, sda_i, sda_oe, mem_write, busy;
  logic [4:0] mem_row, wr_row;
  logic [63:0] mem_page_q, mem_wdata, wr_data;
  logic [63:0] mem [32];
  int wr_cnt = 0, oe_cnt = 0, busy_cnt = 0, total = 0, passed = 0;
  vec_t vecs [4];
  always #5 clk = ~clk;
  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;
  assign mem_page_q = mem[mem_row];
  i2c_eeprom_slave_ctrl dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .mem_row(mem_row), .mem_page_q(mem_page_q), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .busy(busy)
  );
  // array model: byte c of row r holds (8r+c)^0x5A until written
  always @(posedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (mem_init) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 8; c++) mem[r][8*c +: 8] <= 8'(8 * r + c) ^ 8'h5A;
    end else if (mem_write) begin
      mem[mem_row] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      wr_row <= mem_row;
      wr_data <= mem_wdata;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic q();
    repeat (10) @(negedge clk);
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask
  task automatic xfer_bit(input logic b, output logic r);
    m_sda = b; q();
    m_scl = 1'b1; q();
    r = sda_i; q();
    m_scl = 1'b0; q();
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int k = 7; k >= 0; k--) xfer_bit(d[k], r);
    xfer_bit(1'b1, r);
    ack = ~r;
  endtask
  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic r;
    for (int k = 7; k >= 0; k--) xfer_bit(1'b1, d[k]);
    xfer_bit(~ack, r);
  endtask
  task automatic run_vec(input int i);
    int acks, w0;
    logic a;
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    acks = int'(a);
    chk($sformatf("v%0d_busy_on", i), 64'(busy), 64'(1));
    write_byte(vecs[i].waddr, a);
    acks += int'(a);
    for (int k = 0; k < vecs[i].n; k++) begin
      write_byte(vecs[i].d[k], a);
      acks += int'(a);
    end
    i2c_stop();
    chk($sformatf("v%0d_acks", i), 64'(acks), 64'(vecs[i].n + 2));
    chk($sformatf("v%0d_writes", i), 64'(wr_cnt - w0), 64'(1));
    chk($sformatf("v%0d_row", i), 64'(wr_row), 64'(vecs[i].row));
    chk($sformatf("v%0d_page", i), wr_data, vecs[i].page);
    chk($sformatf("v%0d_busy_off", i), 64'(busy), 64'(0));
  endtask
  initial begin
    int w0, o0, b0;
    logic a, r;
    logic [7:0] rd;
    vecs[0] = '{8'h13, 2, 80'h2211, 5'd2, 64'h4D4C4F22_11484B4A};
    vecs[1] = '{8'h06, 3, 80'hCCBBAA, 5'd0, 64'hBBAA5F5E_59585BCC};
    vecs[2] = '{8'h08, 10, 80'h09080706050403020100, 5'd1, 64'h07060504_03020908};
    vecs[3] = '{8'h31, 1, 80'h3C, 5'd6, 64'h6D6C6F6E_69683C6A};
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    chk("rst_sda_oe", 64'(sda_oe), 64'(0));
    chk("rst_mem_write", 64'(mem_write), 64'(0));
    chk("rst_mem_row", 64'(mem_row), 64'(0));
    chk("rst_mem_wdata", mem_wdata, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    q();
    for (int i = 0; i < 3; i++) run_vec(i);
    // random read across the last byte of the array, reading back the wrapped page write
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'hFF, a);
    i2c_start();
    write_byte(8'hA1, a);
    chk("rd_dev_ack", 64'(a), 64'(1));
    read_byte(rd, 1'b1);
    chk("rd_byte0", 64'(rd), 64'(8'hA5));
    read_byte(rd, 1'b0);
    chk("rd_byte1", 64'(rd), 64'(8'hCC));
    i2c_stop();
    chk("rd_no_write", 64'(wr_cnt - w0), 64'(0));
    chk("rd_busy_off", 64'(busy), 64'(0));
    // foreign device address
    w0 = wr_cnt;
    o0 = oe_cnt;
    b0 = busy_cnt;
    i2c_start();
    write_byte(8'hA2, a);
    i2c_stop();
    chk("mis_no_ack", 64'(a), 64'(0));
    chk("mis_oe_quiet", 64'(oe_cnt - o0), 64'(0));
    chk("mis_busy_quiet", 64'(busy_cnt - b0), 64'(0));
    chk("mis_no_write", 64'(wr_cnt - w0), 64'(0));
    // reset with a dirty buffer partway through the second data byte
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h20, a);
    write_byte(8'h77, a);
    xfer_bit(1'b1, r);
    xfer_bit(1'b0, r);
    chk("mid_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_sda_oe", 64'(sda_oe), 64'(0));
    chk("mid_mem_write", 64'(mem_write), 64'(0));
    chk("mid_mem_row", 64'(mem_row), 64'(0));
    chk("mid_mem_wdata", mem_wdata, 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    i2c_stop();
    chk("mid_no_write", 64'(wr_cnt - w0), 64'(0));
    chk("mid_busy_after", 64'(busy), 64'(0));
    run_vec(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
